sec_countdown_timer: RTL and testbench
======================================

Name: sec_countdown_timer

Overview:
- mm:ss countdown timer stage that sits directly downstream of the 1 Hz divider.
- Samples the divider's 1 Hz square wave (clk_1sec) in the 50 MHz clk domain and turns each rising edge into a one-cycle second tick.
- Decrements a BCD minutes:seconds count under a start/pause/load FSM.
- Drives BCD digits toward the seven-segment display stage and flags expiry.

Parameters:
- MAX_MIN, 8'h99, BCD upper limit for minutes accepted on load.

Ports:
- clk  input  1  system clock, 50 MHz; all logic on posedge
- clrn  input  1  asynchronous active-low reset
- clk_1sec  input  1  1 Hz square wave from the divider, generated synchronously to clk
- load  input  1  one-cycle pulse; load min_in/sec_in and go to IDLE
- min_in  input  8  BCD minutes to load (tens in [7:4], units in [3:0])
- sec_in  input  8  BCD seconds to load
- start  input  1  one-cycle pulse; begin or resume counting
- pause  input  1  one-cycle pulse; freeze counting
- min_out  output  8  current BCD minutes, registered
- sec_out  output  8  current BCD seconds, registered
- running  output  1  high in RUN state
- done  output  1  high in DONE state
- load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (clrn=0, asynchronous):
  - state=IDLE, min_out=8'h00, sec_out=8'h00.
  - running=0, done=0, load_err=0.
  - Edge register sec_d=0.
- Tick generation:
  - sec_d <= clk_1sec every cycle.
  - tick = clk_1sec & ~sec_d, high for exactly one clk cycle per rising edge.
  - A tick in the first cycle after reset is harmless because the state is IDLE.
- States: IDLE, RUN, PAUSED, DONE. Input priority per cycle: load > pause > start > tick.
- load, any state:
  - Validity: every digit must be <=9, seconds tens <=5, and min_in <= MAX_MIN.
  - Valid load: registers take min_in/sec_in, state -> IDLE, done clears.
  - Invalid load: count and state unchanged; load_err pulses for 1 cycle.
- start:
  - IDLE or PAUSED with nonzero count -> RUN.
  - IDLE or DONE with count 00:00 -> no change.
  - RUN -> ignored.
  - A tick in the same cycle as start does not decrement; the first decrement happens on the next tick.
- pause:
  - RUN -> PAUSED; a tick in the same cycle is discarded.
  - Any other state -> ignored.
- tick while in RUN, decrement in BCD:
  - Seconds units >0: units-1.
  - Else seconds tens >0: tens-1, units=9.
  - Else (seconds=00, minutes nonzero): seconds=8'h59 and minutes BCD-decrement (units-1, or tens-1 with units=9).
- Expiry: if the decremented result is 00:00, state -> DONE in the same update.
- Latency:
  - clk_1sec rises, then tick is high for one cycle.
  - min_out/sec_out/state update at the clk edge that ends that cycle.
  - So outputs change exactly 1 clk after clk_1sec is first seen high.
- Output encoding:
  - running=(state==RUN) and done=(state==DONE), both registered with the state.
  - No combinational path from any input to any output.
- DONE holds 00:00 until a valid load.
- Reset mid-count returns to IDLE 00:00 immediately, without waiting for clk.
- Ticks in IDLE, PAUSED or DONE are ignored.

Test Plan:
- Bench drives clk_1sec as a square wave with period 10 clk.
- Reset, then load 00:05, start:
  - After 5 ticks: sec_out=8'h00 and done=1 in the same cycle; running=0.
  - 6th tick: no change.
- Load 01:00, start, one tick:
  - min_out=8'h00, sec_out=8'h59.
  - Output changes exactly 1 clk after clk_1sec rises.
- Load 10:00, start, one tick:
  - min_out=8'h09, sec_out=8'h59.
- Load 00:30, start, 3 ticks, pause:
  - sec_out=8'h27; then 5 more ticks leave it 8'h27.
  - start, 2 ticks -> 8'h25.
- Simultaneous events:
  - pause asserted in the same cycle as tick: no decrement, state PAUSED.
  - load and start asserted together: load wins, state IDLE.
- Load sec_in=8'h65, then min_in=8'h1A:
  - Each pulses load_err once; count unchanged.
- Start with 00:00 after reset: state stays IDLE.
- Assert clrn=0 mid-RUN at 00:17: outputs go to 00:00, running=0, without a clk edge.

Source files
------------

// File: rtl/sec_countdown_timer_if.sv
// sec_countdown_timer_if
//   Control and display bundle between a controller (master) and the
//   mm:ss countdown timer (slave).
//   master drives : load, min_in, sec_in, start, pause
//   slave drives  : min_out, sec_out, running, done, load_err
interface sec_countdown_timer_if;
  logic       load;
  logic [7:0] min_in;
  logic [7:0] sec_in;
  logic       start;
  logic       pause;
  logic [7:0] min_out;
  logic [7:0] sec_out;
  logic       running;
  logic       done;
  logic       load_err;

  modport master (
    output load, min_in, sec_in, start, pause,
    input  min_out, sec_out, running, done, load_err
  );

  modport slave (
    input  load, min_in, sec_in, start, pause,
    output min_out, sec_out, running, done, load_err
  );
endinterface

// File: rtl/sec_countdown_timer.sv
// sec_countdown_timer
//   BCD mm:ss countdown stage fed by the 1 Hz divider.  The 1 Hz square wave
//   is edge-detected in the clk domain into a one-cycle tick; a four-state
//   FSM (IDLE/RUN/PAUSED/DONE) decides whether that tick decrements the count.
// Ports
//   clk      : 50 MHz system clock, posedge
//   clrn     : asynchronous active-low reset
//   clk_1sec : 1 Hz square wave, synchronous to clk
//   bus      : slave side of sec_countdown_timer_if
//              (load/min_in/sec_in/start/pause in,
//               min_out/sec_out/running/done/load_err out, all registered)
module sec_countdown_timer #(
  parameter logic [7:0] MAX_MIN = 8'h99
) (
  input  logic                    clk,
  input  logic                    clrn,
  input  logic                    clk_1sec,
  sec_countdown_timer_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t     state_q, state_n;
  logic [7:0] min_q, min_n;
  logic [7:0] sec_q, sec_n;
  logic       running_q, done_q, load_err_q, load_err_n;
  logic       sec_d;
  logic       tick;
  logic       load_ok;
  logic       cnt_zero;
  logic [7:0] min_dec, sec_dec;

  // Rising edge of the 1 Hz wave. Since clk_1sec is produced in the clk
  // domain no synchronizer is needed, and the tick lands in the same cycle
  // the wave is first seen high.
  assign tick = clk_1sec & ~sec_d;

  // Load validation: all BCD digits legal, seconds tens 0..5, and the
  // minutes limit. BCD ordering matches binary ordering for legal digits,
  // so a plain compare against MAX_MIN works.
  assign load_ok = (bus.min_in[7:4] <= 4'd9) && (bus.min_in[3:0] <= 4'd9) &&
                   (bus.sec_in[7:4] <= 4'd5) && (bus.sec_in[3:0] <= 4'd9) &&
                   (bus.min_in <= MAX_MIN);

  assign cnt_zero = (min_q == 8'h00) && (sec_q == 8'h00);

  // One-second BCD decrement with borrow from seconds into minutes.
  // Never used with a zero count: RUN is only entered with a nonzero count
  // and leaves for DONE as soon as zero is reached.
  always_comb begin
    min_dec = min_q;
    sec_dec = sec_q;
    if (sec_q[3:0] != 4'd0) begin
      sec_dec[3:0] = sec_q[3:0] - 4'd1;
    end else if (sec_q[7:4] != 4'd0) begin
      sec_dec[7:4] = sec_q[7:4] - 4'd1;
      sec_dec[3:0] = 4'd9;
    end else begin
      sec_dec = 8'h59;
      if (min_q[3:0] != 4'd0) begin
        min_dec[3:0] = min_q[3:0] - 4'd1;
      end else begin
        min_dec[7:4] = min_q[7:4] - 4'd1;
        min_dec[3:0] = 4'd9;
      end
    end
  end

  // Next state / count. Priority: load > pause > start > tick, so a tick
  // coinciding with pause or start is dropped rather than applied.
  always_comb begin
    state_n    = state_q;
    min_n      = min_q;
    sec_n      = sec_q;
    load_err_n = 1'b0;
    if (bus.load) begin
      if (load_ok) begin
        min_n   = bus.min_in;
        sec_n   = bus.sec_in;
        state_n = IDLE;
      end else begin
        load_err_n = 1'b1;
      end
    end else if (bus.pause) begin
      if (state_q == RUN) state_n = PAUSED;
    end else if (bus.start) begin
      if ((state_q == IDLE || state_q == PAUSED) && !cnt_zero) state_n = RUN;
    end else if (tick && state_q == RUN) begin
      min_n = min_dec;
      sec_n = sec_dec;
      if (min_dec == 8'h00 && sec_dec == 8'h00) state_n = DONE;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= IDLE;
      min_q      <= 8'h00;
      sec_q      <= 8'h00;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
      sec_d      <= 1'b0;
    end else begin
      state_q    <= state_n;
      min_q      <= min_n;
      sec_q      <= sec_n;
      // status flags are flopped from next state so they stay aligned
      // with state_q without a decode after the register
      running_q  <= (state_n == RUN);
      done_q     <= (state_n == DONE);
      load_err_q <= load_err_n;
      sec_d      <= clk_1sec;
    end
  end

  assign bus.min_out  = min_q;
  assign bus.sec_out  = sec_q;
  assign bus.running  = running_q;
  assign bus.done     = done_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_sec_countdown_timer.sv
// tb_sec_countdown_timer
//   Table of single-event vectors, hand sequences for latency / 1 Hz square
//   wave / async reset, and a randomized run against a seconds-based model.
module tb_sec_countdown_timer;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  logic clk_1sec = 1'b0;
  int   n_tot = 0;
  int   n_pass = 0;

  sec_countdown_timer_if bus();

  sec_countdown_timer #(.MAX_MIN(8'h99)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .clk_1sec (clk_1sec),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    string      name;
    logic       ld;
    logic [7:0] mi, si;
    logic       st, pa, tk;
    logic [7:0] emin, esec;
    logic       erun, edone, eerr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic ld, logic [7:0] mi, logic [7:0] si,
                              logic st, logic pa, logic tk, logic [7:0] em,
                              logic [7:0] es, logic er, logic ed, logic ee);
    vec_t v;
    v.name = n; v.ld = ld; v.mi = mi; v.si = si; v.st = st; v.pa = pa; v.tk = tk;
    v.emin = em; v.esec = es; v.erun = er; v.edone = ed; v.eerr = ee;
    return v;
  endfunction

  function automatic logic [18:0] outs();
    return {bus.min_out, bus.sec_out, bus.running, bus.done, bus.load_err};
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_tot++;
    if (got !== exp) $display("FAIL %s: got %h want %h", nm, got, exp);
    else n_pass++;
  endtask

  task automatic idle_in();
    bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
    bus.min_in = 8'h00; bus.sec_in = 8'h00;
  endtask

  // one vector: pulse inputs for one cycle, check, then a quiet cycle
  task automatic apply(vec_t v);
    @(negedge clk);
    bus.load = v.ld; bus.min_in = v.mi; bus.sec_in = v.si;
    bus.start = v.st; bus.pause = v.pa; clk_1sec = v.tk;
    @(negedge clk);
    chk(v.name, 32'(outs()), 32'({v.emin, v.esec, v.erun, v.edone, v.eerr}));
    idle_in(); clk_1sec = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_load(logic [7:0] mi, logic [7:0] si);
    @(negedge clk);
    bus.load = 1'b1; bus.min_in = mi; bus.sec_in = si;
    @(negedge clk);
    idle_in();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // n periods of the 1 Hz wave scaled to 10 clk (5 high, 5 low)
  task automatic sq_ticks(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); clk_1sec = 1'b1;
      repeat (4) @(negedge clk);
      @(negedge clk); clk_1sec = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  // ---------------- reference model: total seconds + status flags --------
  int   m_tot;
  bit   m_run, m_pau, m_done, m_err, m_prev;

  function automatic int bcd(logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] tobcd(int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic bit valid(logic [7:0] mi, logic [7:0] si);
    return (mi[7:4] <= 9) && (mi[3:0] <= 9) && (si[7:4] <= 5) && (si[3:0] <= 9) &&
           (bcd(mi) <= 99);
  endfunction

  task automatic model_reset();
    m_tot = 0; m_run = 0; m_pau = 0; m_done = 0; m_err = 0; m_prev = 0;
  endtask

  task automatic model_step(bit ld, logic [7:0] mi, logic [7:0] si, bit st, bit pa, bit tk);
    m_err = 0;
    if (ld) begin
      if (valid(mi, si)) begin
        m_tot = bcd(mi) * 60 + bcd(si); m_run = 0; m_pau = 0; m_done = 0;
      end else m_err = 1;
    end else if (pa) begin
      if (m_run) begin m_run = 0; m_pau = 1; end
    end else if (st) begin
      if (!m_run && !m_done && m_tot != 0) begin m_run = 1; m_pau = 0; end
    end else if (tk && m_run) begin
      m_tot--;
      if (m_tot == 0) begin m_run = 0; m_done = 1; end
    end
  endtask

  function automatic logic [18:0] model_outs();
    return {tobcd(m_tot / 60), tobcd(m_tot % 60), m_run, m_done, m_err};
  endfunction

  initial begin
    idle_in();

    // table: name ld mi si st pa tk | min sec run done err
    vecs.push_back(mk("start_zero",    0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0));
    vecs.push_back(mk("load_0005",     1, 8'h00, 8'h05, 0, 0, 0, 8'h00, 8'h05, 0, 0, 0));
    vecs.push_back(mk("tick_idle",     0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h05, 0, 0, 0));
    vecs.push_back(mk("start_0005",    0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h05, 1, 0, 0));
    vecs.push_back(mk("tick_04",       0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h04, 1, 0, 0));
    vecs.push_back(mk("tick_03",       0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h03, 1, 0, 0));
    vecs.push_back(mk("tick_02",       0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h02, 1, 0, 0));
    vecs.push_back(mk("tick_01",       0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h01, 1, 0, 0));
    vecs.push_back(mk("tick_expire",   0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 0, 1, 0));
    vecs.push_back(mk("tick_done",     0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 0, 1, 0));
    vecs.push_back(mk("start_done",    0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 1, 0));
    vecs.push_back(mk("load_0100",     1, 8'h01, 8'h00, 0, 0, 0, 8'h01, 8'h00, 0, 0, 0));
    vecs.push_back(mk("start_0100",    0, 8'h00, 8'h00, 1, 0, 0, 8'h01, 8'h00, 1, 0, 0));
    vecs.push_back(mk("borrow_min",    0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h59, 1, 0, 0));
    vecs.push_back(mk("load_1000",     1, 8'h10, 8'h00, 0, 0, 0, 8'h10, 8'h00, 0, 0, 0));
    vecs.push_back(mk("start_1000",    0, 8'h00, 8'h00, 1, 0, 0, 8'h10, 8'h00, 1, 0, 0));
    vecs.push_back(mk("borrow_tens",   0, 8'h00, 8'h00, 0, 0, 1, 8'h09, 8'h59, 1, 0, 0));
    vecs.push_back(mk("load_0030",     1, 8'h00, 8'h30, 0, 0, 0, 8'h00, 8'h30, 0, 0, 0));
    vecs.push_back(mk("start_0030",    0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h30, 1, 0, 0));
    vecs.push_back(mk("tick_29",       0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h29, 1, 0, 0));
    vecs.push_back(mk("tick_28",       0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h28, 1, 0, 0));
    vecs.push_back(mk("tick_27",       0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h27, 1, 0, 0));
    vecs.push_back(mk("pause_w_tick",  0, 8'h00, 8'h00, 0, 1, 1, 8'h00, 8'h27, 0, 0, 0));
    vecs.push_back(mk("tick_paused",   0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h27, 0, 0, 0));
    vecs.push_back(mk("tick_paused2",  0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h27, 0, 0, 0));
    vecs.push_back(mk("resume",        0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h27, 1, 0, 0));
    vecs.push_back(mk("tick_26",       0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h26, 1, 0, 0));
    vecs.push_back(mk("tick_25",       0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h25, 1, 0, 0));
    vecs.push_back(mk("pause_plain",   0, 8'h00, 8'h00, 0, 1, 0, 8'h00, 8'h25, 0, 0, 0));
    vecs.push_back(mk("start_w_tick",  0, 8'h00, 8'h00, 1, 0, 1, 8'h00, 8'h25, 1, 0, 0));
    vecs.push_back(mk("tick_24",       0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h24, 1, 0, 0));
    vecs.push_back(mk("load_w_start",  1, 8'h00, 8'h10, 1, 0, 0, 8'h00, 8'h10, 0, 0, 0));
    vecs.push_back(mk("bad_sec_65",    1, 8'h00, 8'h65, 0, 0, 0, 8'h00, 8'h10, 0, 0, 1));
    vecs.push_back(mk("bad_min_1A",    1, 8'h1A, 8'h00, 0, 0, 0, 8'h00, 8'h10, 0, 0, 1));
    vecs.push_back(mk("bad_sec_0A",    1, 8'h00, 8'h0A, 0, 0, 0, 8'h00, 8'h10, 0, 0, 1));
    vecs.push_back(mk("max_9959",      1, 8'h99, 8'h59, 0, 0, 0, 8'h99, 8'h59, 0, 0, 0));
    vecs.push_back(mk("start_9959",    0, 8'h00, 8'h00, 1, 0, 0, 8'h99, 8'h59, 1, 0, 0));
    vecs.push_back(mk("bad_in_run",    1, 8'hA0, 8'h00, 0, 0, 0, 8'h99, 8'h59, 1, 0, 1));
    vecs.push_back(mk("start_in_run",  0, 8'h00, 8'h00, 1, 0, 0, 8'h99, 8'h59, 1, 0, 0));
    vecs.push_back(mk("tick_9958",     0, 8'h00, 8'h00, 0, 0, 1, 8'h99, 8'h58, 1, 0, 0));

    // reset state
    clrn = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", 32'(outs()), 32'h0);
    clrn = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // 00:05 with a real 10-clk square wave
    pulse_load(8'h00, 8'h05);
    pulse_start();
    sq_ticks(4);
    chk("sq_after4", 32'(outs()), 32'({8'h00, 8'h01, 1'b1, 1'b0, 1'b0}));
    sq_ticks(1);
    chk("sq_after5", 32'(outs()), 32'({8'h00, 8'h00, 1'b0, 1'b1, 1'b0}));
    sq_ticks(1);
    chk("sq_after6", 32'(outs()), 32'({8'h00, 8'h00, 1'b0, 1'b1, 1'b0}));

    // latency: update lands on the first clk edge with clk_1sec high
    pulse_load(8'h01, 8'h00);
    pulse_start();
    @(negedge clk); clk_1sec = 1'b1;
    #1;
    chk("lat_before", 32'({bus.min_out, bus.sec_out}), 32'h0100);
    @(negedge clk);
    chk("lat_after1", 32'({bus.min_out, bus.sec_out}), 32'h0059);
    repeat (4) @(negedge clk);
    chk("lat_hold", 32'({bus.min_out, bus.sec_out}), 32'h0059);
    clk_1sec = 1'b0;
    repeat (5) @(negedge clk);

    // randomized run against the model
    @(negedge clk); clrn = 1'b0;
    @(negedge clk); clrn = 1'b1;
    model_reset();
    begin
      int ph = 5;
      for (int c = 0; c < 4000; c++) begin
        bit ld, st, pa, c1, tk;
        logic [7:0] mi, si;
        @(negedge clk);
        if (c > 0) chk("rand", 32'(outs()), 32'(model_outs()));
        ld = ($urandom_range(0, 39) == 0);
        st = ($urandom_range(0, 4) == 0);
        pa = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 9) < 7) begin
          mi = 8'($urandom_range(0, 9) < 2 ? 1 : 0);
          si = tobcd($urandom_range(0, 19));
        end else begin
          mi = 8'($urandom);
          si = 8'($urandom);
        end
        c1 = ((ph % 10) < 5);
        ph++;
        tk = c1 & ~m_prev;
        m_prev = c1;
        model_step(ld, mi, si, st, pa, tk);
        bus.load = ld; bus.min_in = mi; bus.sec_in = si;
        bus.start = st; bus.pause = pa; clk_1sec = c1;
      end
      @(negedge clk);
      chk("rand_last", 32'(outs()), 32'(model_outs()));
      idle_in(); clk_1sec = 1'b0;
    end

    // async reset mid-run at 00:17
    repeat (3) @(negedge clk);
    pulse_load(8'h00, 8'h20);
    pulse_start();
    sq_ticks(3);
    chk("pre_rst_0017", 32'(outs()), 32'({8'h00, 8'h17, 1'b1, 1'b0, 1'b0}));
    @(negedge clk);
    #2 clrn = 1'b0;
    #1;
    chk("async_rst", 32'(outs()), 32'h0);
    @(negedge clk); clrn = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
